seg_bus_monitor: RTL and testbench

Readback monitor for the multiplexed seven-segment display bus. It samples the active-low segment lines and active-low digit anodes that the display driver produces, waits for each digit slot to settle, and decodes the segment pattern back to its 4-bit hex value. The result is a per-digit register file with valid and error flags. It sits on the board-facing side of the display path as a self-check, closing the loop on the hex-to-segment encoder.

---
 rtl/seg_mon_pkg.sv | 44 ++++
 rtl/seg_pattern_decode.sv | 21 ++
 rtl/seg_bus_monitor.sv | 198 +++++++++++++++++++
 tb/tb_seg_bus_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_mon_pkg.sv
// Shared definitions for the seven-segment readback monitor: segment patterns,
// FSM states and the pattern-decode result type.
package seg_mon_pkg;

  localparam int CNT_WIDTH = 8;

  // Active-high segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  localparam logic [15:0][6:0] SEG_PATTERNS = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] value;
  } seg_decode_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to hex decoder; exact match only.
// Shared with the encoder-side checker.
module seg_pattern_decode
  import seg_mon_pkg::*;
(
  input  logic [6:0]  seg_i,
  output seg_decode_t result_o
);

  always_comb begin
    result_o       = '0;
    result_o.blank = (seg_i == 7'h00);
    for (int v = 0; v < 16; v++) begin
      if (seg_i == SEG_PATTERNS[v]) begin
        result_o.legal = 1'b1;
        result_o.value = 4'(v);
      end
    end
  end

endmodule

// File: rtl/seg_bus_monitor.sv
// Seven-segment bus readback monitor: synchronizes the multiplexed display bus,
// waits for each digit slot to settle and decodes it into a per-digit register file.
// Optional feature: define SEG_MON_BLANK_EN to accept the all-off pattern as a blank capture.
module seg_bus_monitor
  import seg_mon_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    frame_done
);

  localparam logic [CNT_WIDTH-1:0] STABLE_C = CNT_WIDTH'(STABLE_CYCLES);

`ifdef SEG_MON_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;

  mon_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    upd_q, upd_d;
  logic [2:0]              idx_q, idx_d;
  logic                    frame_q, frame_d;

  logic [NUM_DIGITS-1:0]   an_act;
  logic [NUM_DIGITS-1:0]   seen_next;
  logic                    one_hot;
  logic                    same;
  logic                    capture;
  seg_decode_t             dec;

  // Two-flop synchronizer plus one more stage holding the previous sample for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '1;
      seg_s2_q   <= '1;
      seg_prev_q <= '1;
      an_s1_q    <= '1;
      an_s2_q    <= '1;
      an_prev_q  <= '1;
    end else begin
      seg_s1_q   <= seg_n;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      an_s1_q    <= an_n;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
    end
  end

  assign an_act  = ~an_s2_q;
  assign one_hot = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
  assign same    = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);

  seg_pattern_decode u_decode (
    .seg_i    (~seg_s2_q),
    .result_o (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first sample of a new slot counts as 1; capture fires when the run length hits STABLE_CYCLES
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = TRACK;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      TRACK: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          cnt_d = CNT_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_d == STABLE_C) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = TRACK;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign seen_next = seen_q | an_act;

  // Capture datapath: an illegal pattern keeps the old value but flags the digit
  always_comb begin
    hex_d   = hex_q;
    valid_d = valid_q;
    err_d   = err_q;
    seen_d  = seen_q;
    idx_d   = idx_q;
    upd_d   = 1'b0;
    frame_d = 1'b0;
    if (capture) begin
      upd_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_act[i]) begin
          idx_d = 3'(i);
          if (BLANK_EN && dec.blank) begin
            hex_d[4*i +: 4] = 4'h0;
            valid_d[i]      = 1'b0;
            err_d[i]        = 1'b0;
          end else if (dec.legal) begin
            hex_d[4*i +: 4] = dec.value;
            valid_d[i]      = 1'b1;
            err_d[i]        = 1'b0;
          end else begin
            valid_d[i]      = 1'b0;
            err_d[i]        = 1'b1;
          end
        end
      end
      if (seen_next == '1) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q   <= '0;
      valid_q <= '0;
      err_q   <= '0;
      seen_q  <= '0;
      idx_q   <= '0;
      upd_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      hex_q   <= hex_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      idx_q   <= idx_d;
      upd_q   <= upd_d;
      frame_q <= frame_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign upd         = upd_q;
  assign upd_idx     = idx_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seg_bus_monitor.sv
// Directed, table-driven bench for seg_bus_monitor (4 digits, 4 stable cycles).
// Blank-capture expectations follow SEG_MON_BLANK_EN.
module tb_seg_bus_monitor;

  localparam int NumDigits    = 4;
  localparam int StableCycles = 4;
  localparam int Latency      = 2 + StableCycles;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_err;
  logic        upd;
  logic [2:0]  upd_idx;
  logic        frame_done;

  int          checkCount = 0;
  int          errorCount = 0;
  int          updCount;
  int          frameCount;
  int          firstUpd;
  logic [2:0]  lastIdx;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  segHigh;
    int          hold;
    int          expUpds;
    logic [2:0]  expIdx;
    logic [15:0] expHex;
    logic [3:0]  expValid;
    logic [3:0]  expErr;
    int          expFrames;
  } vec_t;

  vec_t mainVecs[10];
  vec_t frameVecs[5];
  vec_t lastCycleVec;

  always #5 clk = ~clk;

  seg_bus_monitor #(
    .NUM_DIGITS    (NumDigits),
    .STABLE_CYCLES (StableCycles)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .frame_done  (frame_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] segHigh);
    an_n  = an;
    seg_n = ~segHigh;
  endtask

  task automatic runCycles(input int n);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (upd === 1'b1) begin
        updCount++;
        if (firstUpd < 0) firstUpd = c;
        lastIdx = upd_idx;
      end
      if (frame_done === 1'b1) frameCount++;
    end
  endtask

  task automatic clearMonitor();
    updCount   = 0;
    frameCount = 0;
    firstUpd   = -1;
    lastIdx    = '0;
  endtask

  task automatic applyVector(input vec_t v, input string tag);
    applyStimulus(v.an, v.segHigh);
    clearMonitor();
    runCycles(v.hold);
    checkOutput({tag, " upds"}, updCount, v.expUpds);
    if (v.expUpds > 0) begin
      checkOutput({tag, " latency"}, firstUpd, Latency);
      checkOutput({tag, " upd_idx"}, lastIdx, v.expIdx);
    end
    checkOutput({tag, " hex_out"}, hex_out, v.expHex);
    checkOutput({tag, " valid"}, digit_valid, v.expValid);
    checkOutput({tag, " err"}, digit_err, v.expErr);
    checkOutput({tag, " frames"}, frameCount, v.expFrames);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " hex_out"}, hex_out, 16'h0000);
    checkOutput({tag, " valid"}, digit_valid, 4'b0000);
    checkOutput({tag, " err"}, digit_err, 4'b0000);
    checkOutput({tag, " upd"}, upd, 1'b0);
    checkOutput({tag, " upd_idx"}, upd_idx, 3'd0);
    checkOutput({tag, " frame_done"}, frame_done, 1'b0);
  endtask

  initial begin
    // an, seg(active-high), hold, upds, idx, hex, valid, err, frames
    mainVecs[0] = '{4'b1110, 7'h5B, 20, 1, 3'd0, 16'h0002, 4'b0001, 4'b0000, 0};
    mainVecs[1] = '{4'b1110, 7'h06,  8, 1, 3'd0, 16'h0001, 4'b0001, 4'b0000, 0};
    mainVecs[2] = '{4'b1101, 7'h4F,  8, 1, 3'd1, 16'h0031, 4'b0011, 4'b0000, 0};
    mainVecs[3] = '{4'b1011, 7'h66,  8, 1, 3'd2, 16'h0431, 4'b0111, 4'b0000, 0};
    mainVecs[4] = '{4'b0111, 7'h71,  8, 1, 3'd3, 16'hF431, 4'b1111, 4'b0000, 1};
    mainVecs[5] = '{4'b1101, 7'h12,  8, 1, 3'd1, 16'hF431, 4'b1101, 4'b0010, 0};
    mainVecs[6] = '{4'b1101, 7'h7D,  8, 1, 3'd1, 16'hF461, 4'b1111, 4'b0000, 0};
    mainVecs[7] = '{4'b1100, 7'h3F, 12, 0, 3'd0, 16'hF461, 4'b1111, 4'b0000, 0};
    mainVecs[8] = '{4'b1111, 7'h3F,  8, 0, 3'd0, 16'hF461, 4'b1111, 4'b0000, 0};
    mainVecs[9] = '{4'b1110, 7'h6D,  8, 1, 3'd0, 16'hF465, 4'b1111, 4'b0000, 0};

    lastCycleVec = '{4'b1110, 7'h39, 12, 1, 3'd0, 16'hF46C, 4'b1111, 4'b0000, 0};

    frameVecs[0] = '{4'b1011, 7'h5B, 10, 1, 3'd2, 16'h0200, 4'b0100, 4'b0000, 0};
    frameVecs[1] = '{4'b1110, 7'h3F, 10, 1, 3'd0, 16'h0200, 4'b0101, 4'b0000, 0};
    frameVecs[2] = '{4'b1101, 7'h06, 10, 1, 3'd1, 16'h0210, 4'b0111, 4'b0000, 0};
    frameVecs[3] = '{4'b0111, 7'h4F, 10, 1, 3'd3, 16'h3210, 4'b1111, 4'b0000, 1};
`ifdef SEG_MON_BLANK_EN
    frameVecs[4] = '{4'b1011, 7'h00, 10, 1, 3'd2, 16'h3010, 4'b1011, 4'b0000, 0};
`else
    frameVecs[4] = '{4'b1011, 7'h00, 10, 1, 3'd2, 16'h3210, 4'b1011, 4'b0100, 0};
`endif

    rst_n = 1'b0;
    applyStimulus(4'b1111, 7'h00);
    clearMonitor();
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;
    runCycles(4);
    checkOutput("idle upds", updCount, 0);

    for (int i = 0; i < 10; i++) begin
      applyVector(mainVecs[i], $sformatf("main%0d", i));
    end

    // Segment toggling faster than the settle window never captures
    clearMonitor();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1110, (k % 2 == 0) ? 7'h6C : 7'h6D);
      runCycles(StableCycles - 1);
    end
    checkOutput("toggle upds", updCount, 0);
    checkOutput("toggle hex_out", hex_out, 16'hF465);

    // Change lands on the final counting cycle: first pattern dropped, second captured
    clearMonitor();
    applyStimulus(4'b1110, 7'h07);
    runCycles(StableCycles - 1);
    checkOutput("lastcycle early upds", updCount, 0);
    applyVector(lastCycleVec, "lastcycle");

    // Reset mid-count and mid-frame
    clearMonitor();
    applyStimulus(4'b1011, 7'h5B);
    runCycles(3);
    checkOutput("midcount upds", updCount, 0);
    rst_n = 1'b0;
    #2;
    checkReset("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyVector(frameVecs[i], $sformatf("frame%0d", i));
    end

    applyStimulus(4'b1111, 7'h00);
    runCycles(4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
